// File: rtl/axi_lite_ram_pkg.sv
// axi_lite_ram_pkg: response codes, special addresses, pass magic, LFSR seed and address decode
package axi_lite_ram_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [31:0] CONSOLE_ADDR = 32'h1000_0000;
  localparam logic [31:0] PASS_ADDR = 32'h2000_0000;
  localparam logic [31:0] PASS_MAGIC = 32'd123456789;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  typedef enum logic [1:0] {REG_RAM, REG_CONSOLE, REG_PASS, REG_NONE} region_e;
  // word_bits is log2 of the RAM depth in words; byte offset bits never take part in the decode
  function automatic region_e decode(input logic [31:0] addr, input int word_bits);
    if ((addr >> (word_bits + 2)) == 32'd0) return REG_RAM;
    if (addr[31:2] == CONSOLE_ADDR[31:2]) return REG_CONSOLE;
    if (addr[31:2] == PASS_ADDR[31:2]) return REG_PASS;
    return REG_NONE;
  endfunction
endpackage

// File: rtl/axi_lite_ram_lfsr.sv
// axi_lite_ram_lfsr: free-running 16-bit LFSR producing per-channel stall gates
module axi_lite_ram_lfsr import axi_lite_ram_pkg::*; #(
  parameter int STALL_EN = 0
) (
  input  logic       clk,
  input  logic       resetn,
  output logic [4:0] gate
);
  logic [15:0] lfsr;
  logic live;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      lfsr <= LFSR_SEED;
      live <= 1'b0;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      live <= 1'b1;
    end
  // live keeps every ready low while reset is held, since readies are combinational
  assign gate = !live ? 5'h00 : STALL_EN != 0 ? lfsr[4:0] : 5'h1f;
endmodule

// File: rtl/axi_lite_ram.sv
// axi_lite_ram: AXI-Lite slave with inline RAM, console byte port and sticky pass register
module axi_lite_ram import axi_lite_ram_pkg::*; #(
  parameter int MEM_WORDS = 16384,
  parameter int READ_LATENCY = 1,
  parameter int STALL_EN = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  output logic [1:0]  mem_axi_bresp,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic [1:0]  mem_axi_rresp,
  output logic        console_valid,
  output logic [7:0]  console_data,
  output logic        tests_passed
);
  localparam int WB = $clog2(MEM_WORDS);
  localparam logic [2:0] LAT = 3'(READ_LATENCY - 1);
  logic [31:0] ram [MEM_WORDS];
  logic [4:0] gate;
  logic aw_full, w_full, rd_busy, commit, ar_hs;
  logic [31:0] aw_addr, w_data;
  logic [3:0] w_strb;
  logic [2:0] lat_cnt;
  region_e w_reg, r_reg;
  axi_lite_ram_lfsr #(.STALL_EN(STALL_EN)) u_lfsr (
    .clk(clk),
    .resetn(resetn),
    .gate(gate)
  );
  assign mem_axi_arready = !rd_busy && gate[0];
  assign mem_axi_awready = !aw_full && gate[1];
  assign mem_axi_wready = !w_full && gate[2];
  assign w_reg = decode(aw_addr, WB);
  assign r_reg = decode(mem_axi_araddr, WB);
  // slots stay full while bvalid is up, so a write commits exactly once
  assign commit = aw_full && w_full && !mem_axi_bvalid && gate[4];
  assign ar_hs = mem_axi_arvalid && mem_axi_arready;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      aw_full <= 1'b0;
      w_full <= 1'b0;
      aw_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
      mem_axi_bvalid <= 1'b0;
      mem_axi_bresp <= RESP_OKAY;
      console_valid <= 1'b0;
      console_data <= '0;
      tests_passed <= 1'b0;
    end else begin
      console_valid <= commit && w_reg == REG_CONSOLE;
      if (mem_axi_awvalid && mem_axi_awready) begin
        aw_full <= 1'b1;
        aw_addr <= mem_axi_awaddr;
      end
      if (mem_axi_wvalid && mem_axi_wready) begin
        w_full <= 1'b1;
        w_data <= mem_axi_wdata;
        w_strb <= mem_axi_wstrb;
      end
      if (commit) begin
        mem_axi_bvalid <= 1'b1;
        mem_axi_bresp <= w_reg == REG_NONE ? RESP_SLVERR : RESP_OKAY;
        if (w_reg == REG_CONSOLE) console_data <= w_data[7:0];
        if (w_reg == REG_PASS && w_data == PASS_MAGIC) tests_passed <= 1'b1;
      end
      if (mem_axi_bvalid && mem_axi_bready) begin
        mem_axi_bvalid <= 1'b0;
        aw_full <= 1'b0;
        w_full <= 1'b0;
      end
    end
  always_ff @(posedge clk)
    if (commit && w_reg == REG_RAM)
      for (int i = 0; i < 4; i++)
        if (w_strb[i]) ram[aw_addr[WB+1:2]][8*i +: 8] <= w_data[8*i +: 8];
  // read data is captured at the AR handshake, so a same-edge write is not visible
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rd_busy <= 1'b0;
      lat_cnt <= '0;
      mem_axi_rvalid <= 1'b0;
      mem_axi_rdata <= '0;
      mem_axi_rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      rd_busy <= 1'b1;
      lat_cnt <= LAT;
      mem_axi_rdata <= r_reg == REG_RAM ? ram[mem_axi_araddr[WB+1:2]] :
                       r_reg == REG_PASS ? {31'b0, tests_passed} : 32'h0;
      mem_axi_rresp <= r_reg == REG_RAM || r_reg == REG_PASS ? RESP_OKAY : RESP_SLVERR;
    end else if (mem_axi_rvalid) begin
      if (mem_axi_rready) begin
        mem_axi_rvalid <= 1'b0;
        rd_busy <= 1'b0;
      end
    end else if (rd_busy) begin
      if (lat_cnt != 3'd0) lat_cnt <= lat_cnt - 3'd1;
      else if (gate[3]) mem_axi_rvalid <= 1'b1;
    end
endmodule

// File: tb/tb_axi_lite_ram.sv
// tb_axi_lite_ram: scoreboard bench; instance 0 runs directed timing without stalls, instance 1 random traffic with stalls
module tb_axi_lite_ram;
  localparam logic [31:0] MAGIC = 32'd123456789;
  logic clk = 1'b0;
  logic resetn [2];
  logic awvalid [2], awready [2], wvalid [2], wready [2], bvalid [2], bready [2];
  logic arvalid [2], arready [2], rvalid [2], rready [2], cvalid [2], tpass [2];
  logic [31:0] awaddr [2], wdata [2], araddr [2], rdata [2];
  logic [3:0] wstrb [2];
  logic [1:0] bresp [2], rresp [2];
  logic [7:0] cdata [2];
  int n_checks = 0, n_fail = 0;
  logic [1:0] bq0 [$], bq1 [$];
  logic [33:0] rq0 [$], rq1 [$];
  logic [7:0] cq0 [$], cq1 [$];
  logic [31:0] mdl [2][1024];
  logic tp [2];
  logic pb_v [2], pb_hs [2], pr_v [2], pr_hs [2];
  logic [1:0] pb_resp [2];
  logic [33:0] pr_data [2];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 2; i++) begin : g
    axi_lite_ram #(.MEM_WORDS(i == 0 ? 1024 : 64), .READ_LATENCY(i == 0 ? 3 : 2), .STALL_EN(i)) dut (
      .clk(clk), .resetn(resetn[i]),
      .mem_axi_awvalid(awvalid[i]), .mem_axi_awready(awready[i]), .mem_axi_awaddr(awaddr[i]),
      .mem_axi_wvalid(wvalid[i]), .mem_axi_wready(wready[i]), .mem_axi_wdata(wdata[i]), .mem_axi_wstrb(wstrb[i]),
      .mem_axi_bvalid(bvalid[i]), .mem_axi_bready(bready[i]), .mem_axi_bresp(bresp[i]),
      .mem_axi_arvalid(arvalid[i]), .mem_axi_arready(arready[i]), .mem_axi_araddr(araddr[i]),
      .mem_axi_rvalid(rvalid[i]), .mem_axi_rready(rready[i]), .mem_axi_rdata(rdata[i]), .mem_axi_rresp(rresp[i]),
      .console_valid(cvalid[i]), .console_data(cdata[i]), .tests_passed(tpass[i])
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int region(input int d, input logic [31:0] a);
    if (a < 32'(d == 0 ? 4096 : 256)) return 0;
    if (a[31:2] == 30'h0400_0000) return 1;
    if (a[31:2] == 30'h0800_0000) return 2;
    return 3;
  endfunction

  function automatic int bsize(input int d);
    return d == 0 ? bq0.size() : bq1.size();
  endfunction

  function automatic int rsize(input int d);
    return d == 0 ? rq0.size() : rq1.size();
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s);
    int r;
    r = region(d, a);
    if (r == 0)
      for (int k = 0; k < 4; k++)
        if (s[k]) mdl[d][a[11:2]][8*k +: 8] = dat[8*k +: 8];
    if (r == 1) begin
      if (d == 0) cq0.push_back(dat[7:0]);
      else cq1.push_back(dat[7:0]);
    end
    if (r == 2 && dat == MAGIC) tp[d] = 1'b1;
    if (d == 0) bq0.push_back(r == 3 ? 2'b10 : 2'b00);
    else bq1.push_back(r == 3 ? 2'b10 : 2'b00);
  endtask

  function automatic logic [33:0] model_read(input int d, input logic [31:0] a);
    int r;
    r = region(d, a);
    if (r == 0) return {2'b00, mdl[d][a[11:2]]};
    if (r == 2) return {2'b00, 31'b0, tp[d]};
    return {2'b10, 32'h0};
  endfunction

  task automatic push_r(input int d, input logic [31:0] a);
    if (d == 0) rq0.push_back(model_read(0, a));
    else rq1.push_back(model_read(1, a));
  endtask

  task automatic wait_b(input int d);
    int t = 0;
    while (bsize(d) != 0 && t < 200) begin
      bready[d] = d == 0 || $urandom_range(0, 2) != 0;
      @(negedge clk); #1;
      @(posedge clk); #1;
      t++;
    end
    bready[d] = 1'b0;
    check("b_drained", bsize(d), 0);
    if (d == 0) bq0.delete(); else bq1.delete();
  endtask

  task automatic wait_r(input int d);
    int t = 0;
    while (rsize(d) != 0 && t < 200) begin
      rready[d] = d == 0 || $urandom_range(0, 2) != 0;
      @(negedge clk); #1;
      @(posedge clk); #1;
      t++;
    end
    rready[d] = 1'b0;
    check("r_drained", rsize(d), 0);
    if (d == 0) rq0.delete(); else rq1.delete();
  endtask

  task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s,
                          input int aw_at, input int w_at);
    logic aw_ok, w_ok;
    bit aw_done = 0, w_done = 0;
    int t = 0;
    model_write(d, a, dat, s);
    awaddr[d] = a;
    wdata[d] = dat;
    wstrb[d] = s;
    while (!(aw_done && w_done) && t < 200) begin
      awvalid[d] = !aw_done && t >= aw_at;
      wvalid[d] = !w_done && t >= w_at;
      @(negedge clk);
      aw_ok = awvalid[d] && awready[d];
      w_ok = wvalid[d] && wready[d];
      @(posedge clk); #1;
      aw_done |= aw_ok;
      w_done |= w_ok;
      t++;
    end
    awvalid[d] = 1'b0;
    wvalid[d] = 1'b0;
    check("aw_w_accept", {aw_done, w_done}, 2'b11);
    wait_b(d);
  endtask

  task automatic do_read(input int d, input logic [31:0] a);
    bit done = 0;
    logic ok;
    int t = 0;
    push_r(d, a);
    araddr[d] = a;
    while (!done && t < 200) begin
      arvalid[d] = 1'b1;
      @(negedge clk);
      ok = arready[d];
      @(posedge clk); #1;
      done = ok;
      t++;
    end
    arvalid[d] = 1'b0;
    check("ar_accept", done, 1);
    wait_r(d);
  endtask

  // monitor: scoreboard pops on every handshake and console pulse; valids must hold until accepted
  always @(negedge clk) begin
    logic [1:0] eb;
    logic [33:0] er;
    logic [7:0] ec;
    for (int d = 0; d < 2; d++)
      if (!resetn[d]) begin
        pb_v[d] = 1'b0;
        pr_v[d] = 1'b0;
      end else begin
        if (pb_v[d] && !pb_hs[d]) check("b_held", {bvalid[d], bresp[d]}, {1'b1, pb_resp[d]});
        if (pr_v[d] && !pr_hs[d]) check("r_held", {rvalid[d], rresp[d], rdata[d]}, {1'b1, pr_data[d]});
        if (bvalid[d] && bready[d]) begin
          if (bsize(d) == 0) check("b_unexpected", bvalid[d], 0);
          else begin
            eb = d == 0 ? bq0.pop_front() : bq1.pop_front();
            check("bresp", bresp[d], eb);
          end
        end
        if (rvalid[d] && rready[d]) begin
          if (rsize(d) == 0) check("r_unexpected", rvalid[d], 0);
          else begin
            er = d == 0 ? rq0.pop_front() : rq1.pop_front();
            check("rresp_rdata", {rresp[d], rdata[d]}, er);
          end
        end
        if (cvalid[d]) begin
          if ((d == 0 ? cq0.size() : cq1.size()) == 0) check("console_unexpected", cvalid[d], 0);
          else begin
            ec = d == 0 ? cq0.pop_front() : cq1.pop_front();
            check("console_data", cdata[d], ec);
          end
        end
        pb_v[d] = bvalid[d];
        pb_hs[d] = bvalid[d] && bready[d];
        pb_resp[d] = bresp[d];
        pr_v[d] = rvalid[d];
        pr_hs[d] = rvalid[d] && rready[d];
        pr_data[d] = {rresp[d], rdata[d]};
      end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, dat;
    int k;
    for (int d = 0; d < 2; d++) begin
      resetn[d] = 1'b0;
      awvalid[d] = 1'b0; wvalid[d] = 1'b0; bready[d] = 1'b0; arvalid[d] = 1'b0; rready[d] = 1'b0;
      awaddr[d] = '0; wdata[d] = '0; wstrb[d] = '0; araddr[d] = '0;
      tp[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_outputs", {awready[d], wready[d], arready[d], bvalid[d], rvalid[d], cvalid[d], tpass[d],
                              bresp[d], rresp[d], cdata[d]}, 0);
      check("reset_rdata", rdata[d], 0);
    end
    @(posedge clk); #1;
    resetn[0] = 1'b1;
    resetn[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // W first, AW three cycles later; bvalid one edge after both slots are full
    model_write(0, 32'h100, 32'hDEADBEEF, 4'hF);
    awaddr[0] = 32'h100; wdata[0] = 32'hDEADBEEF; wstrb[0] = 4'hF;
    wvalid[0] = 1'b1;
    @(negedge clk); check("w_ready", wready[0], 1);
    @(posedge clk); #1 wvalid[0] = 1'b0;
    repeat (2) begin
      @(negedge clk); check("w_slot_full", wready[0], 0); check("b_wait_aw", bvalid[0], 0);
      @(posedge clk); #1;
    end
    awvalid[0] = 1'b1;
    @(negedge clk); check("aw_ready", awready[0], 1);
    @(posedge clk); #1 awvalid[0] = 1'b0;
    @(negedge clk); check("b_not_yet", bvalid[0], 0); check("aw_slot_full", awready[0], 0);
    @(posedge clk); #1;
    repeat (2) begin
      @(negedge clk); check("b_commit", {bvalid[0], bresp[0]}, 3'b100);
      @(posedge clk); #1;
    end
    wait_b(0);
    @(negedge clk);
    check("b_dropped", bvalid[0], 0); check("aw_free", awready[0], 1); check("w_free", wready[0], 1);
    @(posedge clk); #1;

    // read with latency 3 and rready low for two cycles
    push_r(0, 32'h100);
    araddr[0] = 32'h100; arvalid[0] = 1'b1;
    @(negedge clk); check("ar_ready", arready[0], 1);
    @(posedge clk); #1 arvalid[0] = 1'b0;
    repeat (3) begin
      @(negedge clk); check("r_latency", rvalid[0], 0); check("ar_busy", arready[0], 0);
      @(posedge clk); #1;
    end
    repeat (2) begin
      @(negedge clk); check("r_stalled", {rvalid[0], rresp[0], rdata[0]}, {3'b100, 32'hDEADBEEF});
      @(posedge clk); #1;
    end
    wait_r(0);
    @(negedge clk); check("r_dropped", rvalid[0], 0); check("ar_free", arready[0], 1);
    @(posedge clk); #1;

    // partial strobes, special addresses, boundaries, both slot orders
    do_write(0, 32'h100, 32'h11223344, 4'b0101, 0, 0);
    push_r(0, 32'h103);
    rq0.delete();
    rq0.push_back({2'b00, 32'hDE22BE44});
    araddr[0] = 32'h103;
    arvalid[0] = 1'b1;
    @(posedge clk); #1 arvalid[0] = 1'b0;
    wait_r(0);
    do_write(0, 32'h1000_0000, 32'd65, 4'hF, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    check("console_drained", cq0.size(), 0);
    do_write(0, 32'h2000_0000, 32'd5, 4'hF, 0, 0);
    @(negedge clk); check("pass_wrong_magic", tpass[0], 0);
    @(posedge clk); #1;
    do_write(0, 32'h2000_0000, MAGIC, 4'hF, 0, 2);
    @(negedge clk); check("pass_set", tpass[0], 1);
    @(posedge clk); #1;
    do_read(0, 32'h2000_0000);
    do_write(0, 32'h3000_0000, 32'hFFFF_FFFF, 4'hF, 2, 0);
    do_read(0, 32'h100);
    do_read(0, 32'h1000_0000);
    do_write(0, 32'h0000_0FFC, 32'hCAFEF00D, 4'hF, 3, 0);
    do_write(0, 32'h0000_1000, 32'h12345678, 4'hF, 0, 3);
    do_read(0, 32'h0000_0FFC);
    do_read(0, 32'h0000_1000);
    do_read(0, 32'h3000_0000);

    // stalling instance: fill, then random traffic against the model
    for (int i = 0; i < 64; i++)
      do_write(1, 32'(i * 4), $urandom, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2));
    for (int n = 0; n < 1000; n++) begin
      k = $urandom_range(0, 19);
      a = k < 15 ? 32'($urandom_range(0, 255)) : k == 15 ? 32'h1000_0000 + 32'($urandom_range(0, 3)) :
          k == 16 ? 32'h2000_0000 : k == 17 ? 32'h100 : k == 18 ? 32'h0000_00FC : 32'h3000_0000;
      dat = (k == 16 && $urandom_range(0, 1) == 1) ? MAGIC : $urandom;
      if ($urandom_range(0, 1) == 1) do_write(1, a, dat, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      else do_read(1, a);
    end
    @(negedge clk); check("pass_random", tpass[1], tp[1]);
    check("console_random_drained", cq1.size(), 0);
    @(posedge clk); #1;

    // reset with a write address captured but no data: nothing may commit
    awaddr[1] = 32'h10; wdata[1] = 32'hBAD0BAD0; wstrb[1] = 4'hF;
    awvalid[1] = 1'b1;
    repeat (6) @(posedge clk);
    #1 resetn[1] = 1'b0;
    awvalid[1] = 1'b0;
    #1;
    check("midreset_outputs", {awready[1], wready[1], arready[1], bvalid[1], rvalid[1], cvalid[1], tpass[1],
                               bresp[1], rresp[1], cdata[1]}, 0);
    check("midreset_rdata", rdata[1], 0);
    tp[1] = 1'b0;
    @(posedge clk); #1 resetn[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_read(1, 32'h10);
    do_read(1, 32'h2000_0000);
    check("console_final", cq0.size() + cq1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_lite_ram.md
AXI_LITE_RAM -- requirements
Module: axi_lite_ram

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 16384, meaning RAM depth in 32-bit words (power of two, >=16).
REQ-002 SHALL have parameter READ_LATENCY, default 1, meaning cycles from AR handshake edge to rvalid rise (legal range 1..8).
REQ-003 SHALL have parameter STALL_EN, default 0, meaning 1 enables pseudo-random ready/valid stalls for bus stress.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk and resetn.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 resetn  input  1  asynchronous active-low reset.
REQ-007 mem_axi_awvalid  input  1  write address valid.
REQ-008 mem_axi_awready  output  1  write address ready.
REQ-009 mem_axi_awaddr  input  32  write byte address.
REQ-010 mem_axi_wvalid  input  1  write data valid.
REQ-011 mem_axi_wready  output  1  write data ready.
REQ-012 mem_axi_wdata  input  32  write data.
REQ-013 mem_axi_wstrb  input  4  byte-lane enables.
REQ-014 mem_axi_bvalid  output  1  write response valid.
REQ-015 mem_axi_bready  input  1  write response ready.
REQ-016 mem_axi_bresp  output  2  write response, 00 OKAY, 10 SLVERR.
REQ-017 mem_axi_arvalid  input  1  read address valid.
REQ-018 mem_axi_arready  output  1  read address ready.
REQ-019 mem_axi_araddr  input  32  read byte address.
REQ-020 mem_axi_rvalid  output  1  read data valid.
REQ-021 mem_axi_rready  input  1  read data ready.
REQ-022 mem_axi_rdata  output  32  read data.
REQ-023 mem_axi_rresp  output  2  read response, 00 OKAY, 10 SLVERR.
REQ-024 console_valid  output  1  one-cycle pulse per console write.
REQ-025 console_data  output  8  console byte, valid with console_valid.
REQ-026 tests_passed  output  1  sticky pass flag.

Function
REQ-027 Address map SHALL be: addr < MEM_WORDS*4 -> RAM; 0x1000_0000 -> console; 0x2000_0000 -> pass register; all else unmapped; addr[1:0] ignored.
REQ-028 AW and W slots SHALL be captured independently in either order; awready = !aw_full && gate, wready = !w_full && gate, combinational from registers only.
REQ-029 Edge after both slots are full: commit write, assert bvalid; both captured on the same edge -> bvalid on the next edge.
REQ-030 RAM write SHALL update only lanes with wstrb set; bresp OKAY.
REQ-031 Console write SHALL pulse console_valid one cycle with wdata[7:0]; pass write with wdata == 123456789 SHALL set tests_passed until reset; both OKAY.
REQ-032 Unmapped write SHALL have no side effect and return SLVERR.
REQ-033 bvalid, bresp held until bready; slots freed on B handshake; awready/wready may reassert the following cycle.
REQ-034 One read outstanding; arready = !rd_busy && gate; RAM sampled at AR handshake edge; rvalid rises READ_LATENCY edges later when not stalled.
REQ-035 Read of 0x2000_0000 SHALL return {31'b0, tests_passed} OKAY; console or unmapped read returns 0 with SLVERR.
REQ-036 Read sampled on the same edge a write commits to that word SHALL return pre-write data.
REQ-037 rvalid, rdata, rresp held until rready; rd_busy clears on R handshake; arready earliest the next cycle.
REQ-038 STALL_EN=1: 16-bit LFSR, seed 0xACE1, steps every cycle; bits 0..4 gate arready, awready, wready, rvalid rise, bvalid rise; STALL_EN=0 all gates open.
REQ-039 Once asserted, rvalid and bvalid SHALL never drop before handshake regardless of stall.

Reset
REQ-040 Reset SHALL clear all ready/valid outputs, bresp, rresp, rdata, console_valid, console_data, tests_passed, slots, busy flags, latency counter; LFSR returns to seed.
REQ-041 Reset mid-transaction SHALL drop in-flight transfers; RAM contents retained; no console pulse or RAM write issued.

Structure
REQ-042 Package axi_lite_ram_pkg SHALL hold response codes, console/pass addresses, pass magic 123456789, LFSR seed.
REQ-043 Sub-module axi_lite_ram_lfsr SHALL generate stall gates; RAM array inline.

Verification
REQ-044 W at cycle 0, AW at cycle 3 to 0x100, wdata 0xDEADBEEF, wstrb 1111 -> bvalid cycle 4, OKAY; later read 0x100 -> 0xDEADBEEF.
REQ-045 Read 0x100, READ_LATENCY=3, rready low 2 cycles -> rvalid 3 edges after AR, held stable, OKAY.
REQ-046 Write 0x11223344 wstrb 0101 over 0xDEADBEEF -> read 0xDE22BE44.
REQ-047 Write 65 to 0x1000_0000 -> one console pulse, 0x41; write 123456789 to 0x2000_0000 -> tests_passed 1; write to 0x3000_0000 -> SLVERR, RAM unchanged.
REQ-048 STALL_EN=1, 1000 random reads/writes vs model -> data match, no valid dropped before handshake; resetn low mid-write -> all outputs 0, RAM retained.
